// File: rtl/ym3438_clk_pkg.sv
// ym3438_clk_pkg: shared clock-phase defaults and the slot index type for slot-indexed consumers.
package ym3438_clk_pkg;
    localparam int YM3438_PRESCALE_DEF  = 6;
    localparam int YM3438_NUM_SLOTS_DEF = 24;
    localparam int YM3438_CYCLE_W       = 5;
    typedef logic [YM3438_CYCLE_W-1:0] ym3438_cycle_t;
endpackage

// File: rtl/ym3438_mod_counter.sv
// ym3438_mod_counter: modulo-MOD enabled counter with loadable reset value and wrap flag.
module ym3438_mod_counter #(
    parameter int MOD = 6,
    parameter int W   = 3
) (
    input  logic         MCLK,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] rst_val_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);
    logic [W-1:0] count_q, count_d;
    assign wrap_o  = count_q == W'(MOD - 1);
    assign count_d = !en_i ? count_q : wrap_o ? '0 : count_q + W'(1);
    assign count_o = count_q;
    always_ff @(posedge MCLK) begin
        if (reset) count_q <= rst_val_i;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/ym3438_clk_phase_gen.sv
// ym3438_clk_phase_gen: registered non-overlapping c1/c2 strobes, slot index and frame sync from MCLK.
// Optional freeze input hold is present when YM3438_CLK_HOLD_EN is defined.
module ym3438_clk_phase_gen
    import ym3438_clk_pkg::*;
#(
    parameter int PRESCALE  = YM3438_PRESCALE_DEF,
    parameter int NUM_SLOTS = YM3438_NUM_SLOTS_DEF,
    parameter int CYCLE_W   = YM3438_CYCLE_W
) (
    input  logic               MCLK,
    input  logic               reset,
    input  logic               clk_en,
`ifdef YM3438_CLK_HOLD_EN
    input  logic               hold,
`endif
    output logic               c1,
    output logic               c2,
    output logic [CYCLE_W-1:0] cycle,
    output logic               sync
);
    localparam int PW = $clog2(PRESCALE);

    if (PRESCALE < 2 || PRESCALE % 2 != 0) begin : g_bad_prescale
        $error("PRESCALE must be even and >= 2");
    end
    if (NUM_SLOTS < 2 || NUM_SLOTS > 2 ** CYCLE_W) begin : g_bad_slots
        $error("NUM_SLOTS must be >= 2 and fit in CYCLE_W bits");
    end

    logic          en, c1_d, c2_d, sync_d, slot_wrap, p_wrap_unused;
    logic          c1_q, c2_q, sync_q;
    logic [PW-1:0] p_q;

`ifdef YM3438_CLK_HOLD_EN
    assign en = clk_en & ~hold;
`else
    assign en = clk_en;
`endif

    ym3438_mod_counter #(.MOD(PRESCALE), .W(PW)) u_prescaler (
        .MCLK      (MCLK),
        .reset     (reset),
        .en_i      (en),
        .rst_val_i ('0),
        .count_o   (p_q),
        .wrap_o    (p_wrap_unused)
    );

    // Slot counter advances on the very edge that raises c1, so cycle is stable while c1 is high.
    ym3438_mod_counter #(.MOD(NUM_SLOTS), .W(CYCLE_W)) u_slot (
        .MCLK      (MCLK),
        .reset     (reset),
        .en_i      (c1_d),
        .rst_val_i (CYCLE_W'(NUM_SLOTS - 1)),
        .count_o   (cycle),
        .wrap_o    (slot_wrap)
    );

    assign c1_d   = en & (p_q == '0);
    assign c2_d   = en & (p_q == PW'(PRESCALE / 2));
    assign sync_d = c1_d & slot_wrap;

    always_ff @(posedge MCLK) begin
        if (reset) begin
            c1_q   <= 1'b0;
            c2_q   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            c1_q   <= c1_d;
            c2_q   <= c2_d;
            sync_q <= sync_d;
        end
    end

    assign c1   = c1_q;
    assign c2   = c2_q;
    assign sync = sync_q;
endmodule

// File: tb/tb_ym3438_clk_phase_gen.sv
// tb_ym3438_clk_phase_gen: directed vectors for the clock phase generator (default and PRESCALE=2/NUM_SLOTS=4).
module tb_ym3438_clk_phase_gen;
    logic       MCLK = 1'b0;
    logic       reset = 1'b1;
    logic       clk_en = 1'b0;
    logic       hold = 1'b0;
    logic       c1, c2, sync, c1b, c2b, syncb;
    logic [4:0] cycle;
    logic [1:0] cycleb;
    int         total = 0;
    int         passed = 0;

    always #5 MCLK = ~MCLK;

    ym3438_clk_phase_gen dut (
        .MCLK   (MCLK),
        .reset  (reset),
        .clk_en (clk_en),
`ifdef YM3438_CLK_HOLD_EN
        .hold   (hold),
`endif
        .c1     (c1),
        .c2     (c2),
        .cycle  (cycle),
        .sync   (sync)
    );

    ym3438_clk_phase_gen #(.PRESCALE(2), .NUM_SLOTS(4), .CYCLE_W(2)) dut2 (
        .MCLK   (MCLK),
        .reset  (reset),
        .clk_en (clk_en),
`ifdef YM3438_CLK_HOLD_EN
        .hold   (1'b0),
`endif
        .c1     (c1b),
        .c2     (c2b),
        .cycle  (cycleb),
        .sync   (syncb)
    );

    typedef struct {
        logic       r, e, c1, c2;
        logic [4:0] cyc;
        logic       s;
    } vec_t;
    vec_t vt[$];

    function automatic void v(logic r, logic e, logic ec1, logic ec2, logic [4:0] cyc, logic s);
        vec_t x;
        x.r = r; x.e = e; x.c1 = ec1; x.c2 = ec2; x.cyc = cyc; x.s = s;
        vt.push_back(x);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(logic r, logic e);
        reset = r;
        clk_en = e;
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk4(string tag, logic ec1, logic ec2, logic [4:0] cyc, logic s);
        chk({tag, " c1"}, 32'(c1), 32'(ec1));
        chk({tag, " c2"}, 32'(c2), 32'(ec2));
        chk({tag, " cycle"}, 32'(cycle), 32'(cyc));
        chk({tag, " sync"}, 32'(sync), 32'(s));
    endtask

    initial begin
        // Reset for 3 MCLK, then steady clk_en: c1 at 1,7,13 and c2 at 4,10
        for (int i = 0; i < 3; i++) v(1, 1, 0, 0, 23, 0);
        v(0, 1, 1, 0, 0, 1);
        v(0, 1, 0, 0, 0, 0); v(0, 1, 0, 0, 0, 0);
        v(0, 1, 0, 1, 0, 0);
        v(0, 1, 0, 0, 0, 0); v(0, 1, 0, 0, 0, 0);
        v(0, 1, 1, 0, 1, 0);
        v(0, 1, 0, 0, 1, 0); v(0, 1, 0, 0, 1, 0);
        v(0, 1, 0, 1, 1, 0);
        v(0, 1, 0, 0, 1, 0); v(0, 1, 0, 0, 1, 0);
        v(0, 1, 1, 0, 2, 0);
        // clk_en toggling: period stretches to 12, strobes stay one MCLK wide
        v(0, 1, 0, 0, 2, 0); v(0, 0, 0, 0, 2, 0);
        v(0, 1, 0, 0, 2, 0); v(0, 0, 0, 0, 2, 0);
        v(0, 1, 0, 1, 2, 0); v(0, 0, 0, 0, 2, 0);
        v(0, 1, 0, 0, 2, 0); v(0, 0, 0, 0, 2, 0);
        v(0, 1, 0, 0, 2, 0); v(0, 0, 0, 0, 2, 0);
        v(0, 1, 1, 0, 3, 0); v(0, 0, 0, 0, 3, 0);
        v(0, 1, 0, 0, 3, 0); v(0, 0, 0, 0, 3, 0);
        v(0, 1, 0, 0, 3, 0); v(0, 0, 0, 0, 3, 0);
        v(0, 1, 0, 1, 3, 0); v(0, 0, 0, 0, 3, 0);
        v(0, 1, 0, 0, 3, 0); v(0, 0, 0, 0, 3, 0);
        v(0, 1, 0, 0, 3, 0); v(0, 0, 0, 0, 3, 0);
        v(0, 1, 1, 0, 4, 0);
        // Reset at p=3 kills the pending c2; next c1 restarts at slot 0 with sync
        v(0, 1, 0, 0, 4, 0); v(0, 1, 0, 0, 4, 0);
        v(1, 1, 0, 0, 23, 0);
        v(0, 1, 1, 0, 0, 1);
        v(0, 1, 0, 0, 0, 0); v(0, 1, 0, 0, 0, 0);
        v(0, 1, 0, 1, 0, 0);

        foreach (vt[i]) begin
            step(vt[i].r, vt[i].e);
            chk4($sformatf("row%0d", i), vt[i].c1, vt[i].c2, vt[i].cyc, vt[i].s);
        end

        // Full frame: 25 c1 strobes, both instances checked every MCLK against closed-form schedules
        begin
            int syncs = 0;
            int syncb_cnt = 0;
            step(1, 1);
            chk4("frame reset", 0, 0, 23, 0);
            for (int t = 1; t <= 145; t++) begin
                logic       e1, e2, eb1;
                logic [4:0] ec;
                logic [1:0] ecb;
                step(0, 1);
                e1 = ((t - 1) % 6) == 0;
                e2 = ((t - 1) % 6) == 3;
                ec = 5'(((t - 1) / 6) % 24);
                chk4($sformatf("frame t%0d", t), e1, e2, ec, e1 && ec == 0);
                if (sync) syncs++;
                eb1 = (t % 2) == 1;
                ecb = 2'(((eb1 ? t - 1 : t - 2) / 2) % 4);
                if (t <= 16) begin
                    chk($sformatf("p2 t%0d c1", t), 32'(c1b), 32'(eb1));
                    chk($sformatf("p2 t%0d c2", t), 32'(c2b), 32'(!eb1));
                    chk($sformatf("p2 t%0d cycle", t), 32'(cycleb), 32'(ecb));
                    chk($sformatf("p2 t%0d sync", t), 32'(syncb), 32'(eb1 && ecb == 0));
                    if (syncb) syncb_cnt++;
                end
            end
            chk("frame sync count", 32'(syncs), 32'd2);
            chk("p2 sync count", 32'(syncb_cnt), 32'd2);
        end

`ifdef YM3438_CLK_HOLD_EN
        // Freeze at p=2 for 20 MCLK, then c2 follows once p reaches 3
        step(1, 1);
        step(0, 1);
        chk4("hold c1", 1, 0, 0, 1);
        step(0, 1);
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(0, 1);
            chk4($sformatf("hold%0d", i), 0, 0, 0, 0);
        end
        hold = 1'b0;
        step(0, 1);
        chk4("release p3", 0, 0, 0, 0);
        step(0, 1);
        chk4("release c2", 0, 1, 0, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
